// File: rtl/lc2k_mem_pkg.sv
// Shared types and helpers for the LC2K data-memory interface.
package lc2k_mem_pkg;

    localparam int LC2K_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } lc2k_mem_state_e;

    // The ALU result is a signed word address; negatives and anything past the top word are illegal.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
        logic [31:0] limit;
        limit = 32'd1 << aw;
        return !addr[31] && (addr < limit);
    endfunction

endpackage

// File: rtl/lc2k_mem_timeout_ctr.sv
// Cycle counter that flags when a memory request has waited TIMEOUT cycles.
module lc2k_mem_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && !expired)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/lc2k_mem_initiator.sv
// LC2K data-memory initiator: range check, req/ack handshake with timeout, one-cycle response.
module lc2k_mem_initiator
    import lc2k_mem_pkg::*;
#(
    parameter int DATA_W  = LC2K_DATA_W,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              op_write,
    input  logic [31:0]       op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    lc2k_mem_state_e   state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              ctr_clear, ctr_en, ctr_expired;

    lc2k_mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (ctr_clear),
        .enable  (ctr_en),
        .expired (ctr_expired)
    );

    assign op_ready   = (state_q == IDLE);
    assign stall      = (state_q == BUSY) || ((state_q == IDLE) && op_valid);
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    always_comb begin
        state_d      = state_q;
        mem_req_d    = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        ctr_clear    = 1'b0;
        ctr_en       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (op_valid) begin
                    mem_we_d    = op_write;
                    mem_addr_d  = op_addr[ADDR_W-1:0];
                    mem_wdata_d = op_wdata;
                    if (addr_in_range(op_addr, ADDR_W)) begin
                        state_d   = BUSY;
                        mem_req_d = 1'b1;
                        ctr_clear = 1'b1;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end
                end
            end
            BUSY: begin
                // Ack is checked first so an ack in the last counted cycle still completes.
                if (mem_ack) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_we_q ? '0 : mem_rdata;
                end else if (ctr_expired) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    mem_req_d = 1'b1;
                    ctr_en    = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule
